// File: rtl/enco164_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot request word and streams the
// index of each set bit, in priority order, over a valid/ready handshake.
module enco164_seq #(
   parameter bit PRIO_HIGH = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] x,
   input  logic        ld,
   input  logic        rdy,
   output logic [3:0]  o,
   output logic        vld,
   output logic        idle,
   output logic [4:0]  cnt,
   output logic        ovr
);

   typedef enum logic {S_IDLE = 1'b0, S_SERVE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] p_q, p_d;
   logic [3:0]  o_q, o_d;
   logic        vld_q, vld_d;
   logic        idle_q, idle_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ovr_q, ovr_d;

   // Index of the bit that is served next; the last match in scan order wins.
   function automatic logic [3:0] sel_idx(input logic [15:0] v);
      sel_idx = 4'h0;
      if (PRIO_HIGH) begin
         for (int i = 0; i < 16; i++) begin
            if (v[i]) sel_idx = 4'(i);
         end
      end else begin
         for (int i = 15; i >= 0; i--) begin
            if (v[i]) sel_idx = 4'(i);
         end
      end
   endfunction

   function automatic logic [4:0] popcount(input logic [15:0] v);
      popcount = 5'd0;
      for (int i = 0; i < 16; i++) begin
         popcount = popcount + {4'd0, v[i]};
      end
   endfunction

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         p_q     <= 16'h0000;
         o_q     <= 4'h0;
         vld_q   <= 1'b0;
         idle_q  <= 1'b1;
         cnt_q   <= 5'd0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         o_q     <= o_d;
         vld_q   <= vld_d;
         idle_q  <= idle_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   // Next pending word and state: load when idle, retire one bit per transfer.
   always_comb begin
      p_d     = p_q;
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ld && (x != 16'h0000)) begin
               p_d     = x;
               state_d = S_SERVE;
            end else begin
               p_d     = p_q;
               state_d = S_IDLE;
            end
         end
         S_SERVE: begin
            if (rdy) begin
               p_d     = p_q & ~(16'h0001 << sel_idx(p_q));
               state_d = (p_d == 16'h0000) ? S_IDLE : S_SERVE;
            end else begin
               p_d     = p_q;
               state_d = S_SERVE;
            end
         end
         default: begin
            p_d     = 16'h0000;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are derived from the next pending word so they line up with it after the edge.
   always_comb begin
      vld_d  = (p_d != 16'h0000);
      idle_d = (p_d == 16'h0000);
      cnt_d  = popcount(p_d);
      ovr_d  = (state_q == S_SERVE) && ld;
      if (p_d != 16'h0000) begin
         o_d = sel_idx(p_d);
      end else begin
         o_d = 4'h0;
      end
   end

   assign o    = o_q;
   assign vld  = vld_q;
   assign idle = idle_q;
   assign cnt  = cnt_q;
   assign ovr  = ovr_q;

endmodule

// File: tb/tb_enco164_seq.sv
// Bench for enco164_seq: both priority orders side by side, checked against a
// queue-of-indices reference model.
module tb_enco164_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] x;
   logic        ld;
   logic        rdy;

   logic [3:0] o0, o1;
   logic       vld0, vld1, idle0, idle1, ovr0, ovr1;
   logic [4:0] cnt0, cnt1;

   int vectors = 0;
   int errors  = 0;

   // Model: pending indices in service order for each priority, plus the busy-load flag.
   int   q_lo[$];
   int   q_hi[$];
   logic ovr_m = 1'b0;

   enco164_seq #(.PRIO_HIGH(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .x(x), .ld(ld), .rdy(rdy),
      .o(o0), .vld(vld0), .idle(idle0), .cnt(cnt0), .ovr(ovr0));

   enco164_seq #(.PRIO_HIGH(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .x(x), .ld(ld), .rdy(rdy),
      .o(o1), .vld(vld1), .idle(idle1), .cnt(cnt1), .ovr(ovr1));

   always #5 clk = ~clk;

   wire [11:0] act_lo = {o0, vld0, idle0, cnt0, ovr0};
   wire [11:0] act_hi = {o1, vld1, idle1, cnt1, ovr1};

   function automatic logic [11:0] expv(input bit hi);
      int         n;
      logic [3:0] oe;
      n  = q_lo.size();
      oe = 4'h0;
      if (n != 0) oe = hi ? 4'(q_hi[0]) : 4'(q_lo[0]);
      return {oe, (n != 0), (n == 0), 5'(n), ovr_m};
   endfunction

   task automatic model_load(input logic [15:0] v);
      q_lo.delete();
      q_hi.delete();
      for (int i = 0; i < 16; i++) if (v[i]) q_lo.push_back(i);
      for (int i = 15; i >= 0; i--) if (v[i]) q_hi.push_back(i);
   endtask

   task automatic model_reset();
      q_lo.delete();
      q_hi.delete();
      ovr_m = 1'b0;
   endtask

   // One clock edge; the model consumes the inputs that were present at that edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (q_lo.size() == 0) begin
         ovr_m = 1'b0;
         if (ld && (x != 16'h0000)) model_load(x);
      end else begin
         ovr_m = ld;
         if (rdy) begin
            void'(q_lo.pop_front());
            void'(q_hi.pop_front());
         end
      end
   endtask

   task automatic test_reset();
      logic [11:0] rst_val;
      rst_val = {4'h0, 1'b0, 1'b1, 5'd0, 1'b0};
      rst = 1'b1; ld = 1'b0; rdy = 1'b0; x = 16'h0000;
      #12;
      model_reset();
      vectors++;
      if (act_lo !== rst_val || act_hi !== rst_val) begin
         errors++;
         $display("FAIL reset: got lo=%h hi=%h want %h", act_lo, act_hi, rst_val);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_load();
      ld = 1'b1; x = 16'h0000; rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1) || vld0 !== 1'b0 || idle0 !== 1'b1) begin
            errors++;
            $display("FAIL zero_load c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
      end
      ld = 1'b0;
   endtask

   task automatic test_8421();
      logic [3:0] lo_tab [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
      logic [3:0] hi_tab [4] = '{4'd15, 4'd10, 4'd5, 4'd0};
      ld = 1'b1; x = 16'h8421; rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         ld = 1'b0;
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1)) begin
            errors++;
            $display("FAIL 8421 c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
         if (c < 4) begin
            vectors++;
            if (o0 !== lo_tab[c] || o1 !== hi_tab[c] || cnt0 !== 5'(4 - c)) begin
               errors++;
               $display("FAIL 8421_seq c%0d: got o_lo=%0d o_hi=%0d cnt=%0d want %0d %0d %0d", c, o0, o1, cnt0, lo_tab[c], hi_tab[c], 4 - c);
            end
         end
      end
   endtask

   task automatic test_ffff();
      ld = 1'b1; x = 16'hFFFF; rdy = 1'b1;
      for (int c = 0; c < 17; c++) begin
         tick();
         ld = 1'b0;
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1)) begin
            errors++;
            $display("FAIL ffff c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
         if (c == 0) begin
            vectors++;
            if (cnt1 !== 5'b10000 || o1 !== 4'd15) begin
               errors++;
               $display("FAIL ffff_cnt: got cnt=%0d o=%0d want 16 15", cnt1, o1);
            end
         end
      end
   endtask

   task automatic test_stall();
      ld = 1'b1; x = 16'h0006; rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         ld = 1'b0;
         if (c == 3) rdy = 1'b1;
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1)) begin
            errors++;
            $display("FAIL stall c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
         if (c < 3) begin
            vectors++;
            if (o0 !== 4'd1 || vld0 !== 1'b1 || cnt0 !== 5'd2) begin
               errors++;
               $display("FAIL stall_hold c%0d: got o=%0d vld=%b cnt=%0d want 1 1 2", c, o0, vld0, cnt0);
            end
         end
      end
   endtask

   task automatic test_busy_load();
      ld = 1'b1; x = 16'h0003; rdy = 1'b0;
      tick();
      ld = 1'b1; x = 16'hF000; rdy = 1'b1;
      tick();
      vectors++;
      if (act_lo !== expv(1'b0) || ovr0 !== 1'b1 || o0 !== 4'd1) begin
         errors++;
         $display("FAIL busy_ovr: got %h want %h", act_lo, expv(1'b0));
      end
      tick();
      ld = 1'b0;
      vectors++;
      if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1) || ovr0 !== 1'b1 || vld0 !== 1'b0) begin
         errors++;
         $display("FAIL busy_last: got lo=%h hi=%h want lo=%h hi=%h", act_lo, act_hi, expv(1'b0), expv(1'b1));
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (act_lo !== expv(1'b0) || vld0 !== 1'b0 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_after c%0d: got %h want %h", c, act_lo, expv(1'b0));
         end
      end
   endtask

   task automatic test_async_reset();
      ld = 1'b1; x = 16'h00F0; rdy = 1'b1;
      tick();
      ld = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (vld0 !== 1'b0 || cnt0 !== 5'd0 || o0 !== 4'h0 || idle0 !== 1'b1 || act_hi !== expv(1'b1)) begin
         errors++;
         $display("FAIL async_rst: got lo=%h hi=%h want %h", act_lo, act_hi, expv(1'b1));
      end
      #1 rst = 1'b0;
      ld = 1'b1; x = 16'h0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         ld = 1'b0;
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1)) begin
            errors++;
            $display("FAIL post_rst c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         x   = 16'($urandom) & 16'($urandom);
         ld  = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         tick();
         vectors++;
         if (act_lo !== expv(1'b0) || act_hi !== expv(1'b1)) begin
            errors++;
            $display("FAIL random c%0d: got lo=%h hi=%h want lo=%h hi=%h", c, act_lo, act_hi, expv(1'b0), expv(1'b1));
         end
      end
      ld = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_load();
      test_8421();
      test_ffff();
      test_stall();
      test_busy_load();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
